// File: rtl/vend_sequencer.sv
// Coffee vending transaction controller: coin credit, cup/coffee sequencing, change paid as 1-yuan Refund pulses.
// Latency: vend decision 1 edge after the paying coin; all outputs registered. Optional actuator watchdog: VEND_TIMEOUT_EN.
// Backpressure: none; coins arriving while busy or overflowing credit are bounced via coin_rej_o.
module vend_sequencer #(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 4,
  parameter int MAX_CREDIT  = 15,
  parameter int REFUND_GAP  = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                coin_1_i,
  input  logic                coin_5_i,
  input  logic                coin_return_i,
  input  logic                cup_rdy_i,
  input  logic                cof_rdy_i,
  output logic                place_cup_o,
  output logic                inject_cof_o,
  output logic                refund_o,
  output logic                coin_rej_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                busy_o,
  output logic                fault_o
);

  localparam int SUM_W = CREDIT_W + 3;
  localparam int GAP_W = $clog2(REFUND_GAP);

  typedef enum logic [1:0] {IDLE, CUP, COF, PAYOUT} state_t;

  state_t              state_q, state_d;
  logic                place_cup_q, place_cup_d;
  logic                inject_cof_q, inject_cof_d;
  logic                refund_q, refund_d;
  logic                coin_rej_q, coin_rej_d;
  logic                busy_q, busy_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [SUM_W-1:0]    coin_add, sum, eff_sum;
  logic                overflow;

`ifdef VEND_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             fault_q, fault_d;
  logic             tmo_fire;
  logic [SUM_W-1:0] refill;
`endif

  always_comb begin
    coin_add = SUM_W'(coin_1_i) + (coin_5_i ? SUM_W'(5) : '0);
    sum      = SUM_W'(credit_q) + coin_add;
    overflow = sum > SUM_W'(MAX_CREDIT);
    eff_sum  = overflow ? SUM_W'(credit_q) : sum;
  end

  always_comb begin
    state_d      = state_q;
    place_cup_d  = 1'b0;
    inject_cof_d = 1'b0;
    refund_d     = 1'b0;
    coin_rej_d   = 1'b0;
    credit_d     = credit_q;
    gap_cnt_d    = gap_cnt_q;
`ifdef VEND_TIMEOUT_EN
    tmo_cnt_d = '0;
    fault_d   = fault_q;
    tmo_fire  = 1'b0;
    refill    = SUM_W'(credit_q) + SUM_W'(PRICE);
`endif
    case (state_q)
      IDLE: begin
        coin_rej_d = overflow;
`ifdef VEND_TIMEOUT_EN
        if (!overflow && (coin_add != '0)) fault_d = 1'b0;
`endif
        // A vend wins over a same-cycle return request, which is then dropped.
        if (eff_sum >= SUM_W'(PRICE)) begin
          state_d     = CUP;
          credit_d    = CREDIT_W'(eff_sum - SUM_W'(PRICE));
          place_cup_d = 1'b1;
        end else if (coin_return_i && (eff_sum != '0)) begin
          state_d   = PAYOUT;
          credit_d  = CREDIT_W'(eff_sum);
          refund_d  = 1'b1;
          gap_cnt_d = '0;
        end else begin
          credit_d = CREDIT_W'(eff_sum);
        end
      end
      CUP: begin
        coin_rej_d = coin_1_i | coin_5_i;
        if (cup_rdy_i) begin
          inject_cof_d = 1'b1;
          state_d      = COF;
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) tmo_fire = 1'b1;
`endif
        else begin
          place_cup_d = 1'b1;
`ifdef VEND_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
      end
      COF: begin
        coin_rej_d = coin_1_i | coin_5_i;
        if (cof_rdy_i) begin
          if (credit_q != '0) begin
            state_d   = PAYOUT;
            refund_d  = 1'b1;
            gap_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef VEND_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) tmo_fire = 1'b1;
`endif
        else begin
          inject_cof_d = 1'b1;
`ifdef VEND_TIMEOUT_EN
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
        end
      end
      PAYOUT: begin
        coin_rej_d = coin_1_i | coin_5_i;
        // Credit is debited at the edge that closes each pulse cycle.
        if (refund_q) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_d = IDLE;
        end
        if (state_d == PAYOUT) begin
          if (gap_cnt_q == GAP_W'(REFUND_GAP - 1)) begin
            refund_d  = 1'b1;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef VEND_TIMEOUT_EN
    // Watchdog gives the price back and pays everything out as change.
    if (tmo_fire) begin
      state_d   = PAYOUT;
      fault_d   = 1'b1;
      refund_d  = 1'b1;
      gap_cnt_d = '0;
      credit_d  = (refill > SUM_W'(MAX_CREDIT)) ? CREDIT_W'(MAX_CREDIT) : CREDIT_W'(refill);
    end
`endif
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      place_cup_q  <= 1'b0;
      inject_cof_q <= 1'b0;
      refund_q     <= 1'b0;
      coin_rej_q   <= 1'b0;
      busy_q       <= 1'b0;
      credit_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      place_cup_q  <= place_cup_d;
      inject_cof_q <= inject_cof_d;
      refund_q     <= refund_d;
      coin_rej_q   <= coin_rej_d;
      busy_q       <= busy_d;
      credit_q     <= credit_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
    end
  end
  assign fault_o = fault_q;
`else
  assign fault_o = 1'b0;
`endif

  assign place_cup_o  = place_cup_q;
  assign inject_cof_o = inject_cof_q;
  assign refund_o     = refund_q;
  assign coin_rej_o   = coin_rej_q;
  assign credit_o     = credit_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: main instance at PRICE=3, second instance at PRICE=15 for the credit limit.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_1 = 0, coin_5 = 0, coin_ret = 0, cup_rdy = 0, cof_rdy = 0;
  logic       place, inject, refund, rej, busy, fault;
  logic [3:0] credit;
  logic       b_coin_1 = 0, b_coin_5 = 0, b_coin_ret = 0, b_cup_rdy = 0, b_cof_rdy = 0;
  logic       b_place, b_inject, b_refund, b_rej, b_busy, b_fault;
  logic [3:0] b_credit;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vend_sequencer #(.PRICE(3), .CREDIT_W(4), .MAX_CREDIT(15), .REFUND_GAP(2), .TIMEOUT_CYC(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .coin_1_i(coin_1), .coin_5_i(coin_5), .coin_return_i(coin_ret),
    .cup_rdy_i(cup_rdy), .cof_rdy_i(cof_rdy), .place_cup_o(place), .inject_cof_o(inject),
    .refund_o(refund), .coin_rej_o(rej), .credit_o(credit), .busy_o(busy), .fault_o(fault));

  vend_sequencer #(.PRICE(15), .CREDIT_W(4), .MAX_CREDIT(15), .REFUND_GAP(2), .TIMEOUT_CYC(8)) dut_p15 (
    .clk_i(clk), .rst_n_i(rst_n), .coin_1_i(b_coin_1), .coin_5_i(b_coin_5), .coin_return_i(b_coin_ret),
    .cup_rdy_i(b_cup_rdy), .cof_rdy_i(b_cof_rdy), .place_cup_o(b_place), .inject_cof_o(b_inject),
    .refund_o(b_refund), .coin_rej_o(b_rej), .credit_o(b_credit), .busy_o(b_busy), .fault_o(b_fault));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit c1, input bit c5, input bit ret);
    coin_1 = c1; coin_5 = c5; coin_ret = ret;
    tick();
    coin_1 = 0; coin_5 = 0; coin_ret = 0;
  endtask

  // Walks the payout from the current (already sampled) cycle until Busy drops, bounded.
  task automatic collect_payout(output int n, output int gap, output int idle_at);
    int prev;
    n = 0; gap = -1; idle_at = -1; prev = -1;
    for (int i = 0; i < 16; i++) begin
      if (refund === 1'b1) begin
        n++;
        if (prev >= 0) gap = i - prev;
        prev = i;
      end
      if (busy === 1'b0) begin
        idle_at = i;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({place, inject, refund, rej, busy, fault} !== 6'b0) begin errors++; $display("FAIL rst_flags got %b exp 000000", {place, inject, refund, rej, busy, fault}); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL rst_credit got %0d exp 0", credit); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if ({busy, credit} !== 5'b0) begin errors++; $display("FAIL rst_idle got busy=%b credit=%0d exp busy=0 credit=0", busy, credit); end
  endtask

  task automatic test_exact_pay();
    int n, gap, idle_at;
    pulse(1, 0, 0);
    checks++; if (credit !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL exact_c1 got credit=%0d busy=%b exp 1/0", credit, busy); end
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    checks++; if (place !== 1'b1 || credit !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL exact_vend got place=%b credit=%0d busy=%b exp 1/0/1", place, credit, busy); end
    tick();
    checks++; if (place !== 1'b1 || inject !== 1'b0) begin errors++; $display("FAIL exact_cup_wait got place=%b inject=%b exp 1/0", place, inject); end
    cup_rdy = 1; tick(); cup_rdy = 0;
    checks++; if (place !== 1'b0 || inject !== 1'b1) begin errors++; $display("FAIL exact_cof got place=%b inject=%b exp 0/1", place, inject); end
    cof_rdy = 1; tick(); cof_rdy = 0;
    checks++; if (inject !== 1'b0 || busy !== 1'b0 || credit !== 4'd0) begin errors++; $display("FAIL exact_done got inject=%b busy=%b credit=%0d exp 0/0/0", inject, busy, credit); end
    collect_payout(n, gap, idle_at);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (refund === 1'b1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL exact_refunds got %0d exp 0", n); end
  endtask

  task automatic test_change();
    int n, gap, idle_at;
    pulse(0, 1, 0);
    checks++; if (place !== 1'b1 || credit !== 4'd2) begin errors++; $display("FAIL chg_vend got place=%b credit=%0d exp 1/2", place, credit); end
    cup_rdy = 1; tick(); cup_rdy = 0;
    cof_rdy = 1; tick(); cof_rdy = 0;
    checks++; if (refund !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL chg_first got refund=%b busy=%b exp 1/1", refund, busy); end
    collect_payout(n, gap, idle_at);
    checks++; if (n !== 2) begin errors++; $display("FAIL chg_count got %0d exp 2", n); end
    checks++; if (gap !== 2) begin errors++; $display("FAIL chg_gap got %0d exp 2", gap); end
    checks++; if (credit !== 4'd0 || idle_at !== 3) begin errors++; $display("FAIL chg_end got credit=%0d idle_at=%0d exp 0/3", credit, idle_at); end
  endtask

  task automatic test_return();
    int n, gap, idle_at;
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    checks++; if (credit !== 4'd2 || busy !== 1'b0) begin errors++; $display("FAIL ret_credit got %0d busy=%b exp 2/0", credit, busy); end
    pulse(0, 0, 1);
    checks++; if (refund !== 1'b1 || credit !== 4'd2) begin errors++; $display("FAIL ret_start got refund=%b credit=%0d exp 1/2", refund, credit); end
    collect_payout(n, gap, idle_at);
    checks++; if (n !== 2 || gap !== 2) begin errors++; $display("FAIL ret_pulses got n=%0d gap=%0d exp 2/2", n, gap); end
    checks++; if (idle_at !== 3 || credit !== 4'd0) begin errors++; $display("FAIL ret_end got idle_at=%0d credit=%0d exp 3/0", idle_at, credit); end
    pulse(0, 0, 1);
    tick();
    checks++; if ({busy, refund, rej} !== 3'b0 || credit !== 4'd0) begin errors++; $display("FAIL ret_zero got busy/refund/rej=%b credit=%0d exp 000/0", {busy, refund, rej}, credit); end
  endtask

  task automatic test_simultaneous();
    int n, gap, idle_at;
    pulse(1, 1, 0);
    checks++; if (place !== 1'b1 || credit !== 4'd3) begin errors++; $display("FAIL sim_vend got place=%b credit=%0d exp 1/3", place, credit); end
    cup_rdy = 1; tick(); cup_rdy = 0;
    cof_rdy = 1; tick(); cof_rdy = 0;
    collect_payout(n, gap, idle_at);
    checks++; if (n !== 3 || idle_at !== 5) begin errors++; $display("FAIL sim_payout got n=%0d idle_at=%0d exp 3/5", n, idle_at); end
  endtask

  task automatic test_limit();
    b_coin_5 = 1; tick(); tick(); b_coin_5 = 0;
    b_coin_1 = 1; tick(); tick(); b_coin_1 = 0;
    checks++; if (b_credit !== 4'd12 || b_rej !== 1'b0) begin errors++; $display("FAIL lim_fill got credit=%0d rej=%b exp 12/0", b_credit, b_rej); end
    b_coin_5 = 1; tick(); b_coin_5 = 0;
    checks++; if (b_rej !== 1'b1 || b_credit !== 4'd12) begin errors++; $display("FAIL lim_rej got rej=%b credit=%0d exp 1/12", b_rej, b_credit); end
    tick();
    checks++; if (b_rej !== 1'b0) begin errors++; $display("FAIL lim_rej_pulse got %b exp 0", b_rej); end
    b_coin_1 = 1; b_coin_5 = 1; tick(); b_coin_1 = 0; b_coin_5 = 0;
    checks++; if (b_rej !== 1'b1 || b_credit !== 4'd12) begin errors++; $display("FAIL lim_rej6 got rej=%b credit=%0d exp 1/12", b_rej, b_credit); end
    b_coin_1 = 1; tick(); tick(); tick(); b_coin_1 = 0;
    checks++; if (b_place !== 1'b1 || b_credit !== 4'd0 || b_rej !== 1'b0) begin errors++; $display("FAIL lim_vend15 got place=%b credit=%0d rej=%b exp 1/0/0", b_place, b_credit, b_rej); end
  endtask

  task automatic test_busy_reject();
    pulse(0, 1, 0);
    pulse(1, 0, 0);
    checks++; if (rej !== 1'b1 || credit !== 4'd2 || place !== 1'b1) begin errors++; $display("FAIL busy_rej got rej=%b credit=%0d place=%b exp 1/2/1", rej, credit, place); end
    pulse(0, 0, 1);
    checks++; if (rej !== 1'b0 || refund !== 1'b0 || credit !== 4'd2) begin errors++; $display("FAIL busy_ret_ign got rej=%b refund=%b credit=%0d exp 0/0/2", rej, refund, credit); end
    cup_rdy = 1; tick(); cup_rdy = 0;
    checks++; if (inject !== 1'b1) begin errors++; $display("FAIL busy_cof got inject=%b exp 1", inject); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({place, inject, refund, rej, busy} !== 5'b0 || credit !== 4'd0) begin errors++; $display("FAIL async_rst got flags=%b credit=%0d exp 00000/0", {place, inject, refund, rej, busy}, credit); end
    #3 rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || place !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL post_rst got busy=%b place=%b fault=%b exp 0/0/0", busy, place, fault); end
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    int n, gap, idle_at;
    int early;
    early = 0;
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      if (fault !== 1'b0 || place !== 1'b1) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d bad cycles exp 0", early); end
    tick();
    checks++; if (fault !== 1'b1 || place !== 1'b0 || credit !== 4'd3) begin errors++; $display("FAIL tmo_fire got fault=%b place=%b credit=%0d exp 1/0/3", fault, place, credit); end
    collect_payout(n, gap, idle_at);
    checks++; if (n !== 3) begin errors++; $display("FAIL tmo_refunds got %0d exp 3", n); end
    pulse(1, 0, 0);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmo_clear got fault=%b exp 0", fault); end
  endtask
`endif

  initial begin
    test_reset();
    test_exact_pay();
    test_change();
    test_return();
    test_simultaneous();
    test_limit();
    test_busy_reject();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, exp finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
